// File: rtl/divider_pkg.sv
// divider_pkg: state encoding and default width shared by
// the restoring divider and its step datapath.
package divider_pkg;
   localparam int DIV_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } div_state_t;
endpackage

// File: rtl/divider_step.sv
// divider_step: one restoring step -- shift in a dividend bit,
// trial-subtract the divisor, keep or restore.
module divider_step
   import divider_pkg::*;
#(
   parameter int N = DIV_W
) (
   input  logic [N:0]   rem,
   input  logic [N-1:0] divisor,
   input  logic         din,
   output logic [N:0]   rem_next,
   output logic         qbit
);
   logic [N+1:0] shifted;
   logic [N+1:0] diff;

   assign shifted  = {rem, din};
   // Top bit of the widened difference is the borrow/sign.
   assign diff     = shifted - {2'b00, divisor};
   assign qbit     = ~diff[N+1];
   assign rem_next = qbit ? diff[N:0] : shifted[N:0];
endmodule

// File: rtl/restoring_divider.sv
// restoring_divider: 2N/N restoring divider, one bit per clock.
// Define DIVIDER_SIGNED_EN for two's-complement operands.
module restoring_divider
   import divider_pkg::*;
#(
   parameter int N = DIV_W
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           en,
   input  logic [2*N-1:0] A,
   input  logic [N-1:0]   B,
   output logic [N-1:0]   Quotient,
   output logic [N-1:0]   Remainder,
   output logic           ready,
   output logic           div_zero,
   output logic           overflow
);
   localparam int CW = $clog2(N + 1);

   div_state_t    state;
   logic [N:0]    prem;
   logic [N-1:0]  bq;
   logic [N-1:0]  alo;
   logic [N-2:0]  qacc;
   logic [CW-1:0] cnt;

   logic [N:0]     prem_nx;
   logic           qbit;
   logic [2*N-1:0] a_mag;
   logic [N-1:0]   b_mag;
   logic [N-1:0]   q_fin;
   logic [N-1:0]   r_fin;
   logic [N-1:0]   q_res;
   logic [N-1:0]   r_res;
   logic           q_ovf;

   divider_step #(.N(N)) u_step (
      .rem      (prem),
      .divisor  (bq),
      .din      (alo[N-1]),
      .rem_next (prem_nx),
      .qbit     (qbit)
   );

   assign q_fin = {qacc, qbit};
   assign r_fin = prem_nx[N-1:0];

`ifdef DIVIDER_SIGNED_EN
   localparam logic [N-1:0] QMAX = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] QMIN = {1'b1, {(N-1){1'b0}}};

   logic         neg_q;
   logic         neg_r;
   logic [N-1:0] a_orig;
   logic [N-1:0] q_out;
   logic [N-1:0] r_out;

   assign a_mag = A[2*N-1] ? -A : A;
   assign b_mag = B[N-1] ? -B : B;
   assign q_ovf = neg_q ? (q_fin > QMIN) : (q_fin > QMAX);
   assign q_out = neg_q ? -q_fin : q_fin;
   assign r_out = neg_r ? -r_fin : r_fin;
   assign q_res = q_ovf ? '1 : q_out;
   assign r_res = q_ovf ? a_orig : r_out;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         a_orig <= '0;
      end else if (state == IDLE && en) begin
         neg_q  <= A[2*N-1] ^ B[N-1];
         neg_r  <= A[2*N-1];
         a_orig <= A[N-1:0];
      end
   end
`else
   assign a_mag = A;
   assign b_mag = B;
   assign q_ovf = 1'b0;
   assign q_res = q_fin;
   assign r_res = r_fin;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         Quotient  <= '0;
         Remainder <= '0;
         ready     <= 1'b0;
         div_zero  <= 1'b0;
         overflow  <= 1'b0;
         prem      <= '0;
         bq        <= '0;
         alo       <= '0;
         qacc      <= '0;
         cnt       <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (en) begin
                  ready    <= 1'b0;
                  div_zero <= 1'b0;
                  overflow <= 1'b0;
                  cnt      <= '0;
                  qacc     <= '0;
                  bq       <= b_mag;
                  alo      <= a_mag[N-1:0];
                  prem     <= {1'b0, a_mag[2*N-1:N]};
                  if (B == '0) begin
                     state     <= DONE;
                     ready     <= 1'b1;
                     div_zero  <= 1'b1;
                     Quotient  <= '1;
                     Remainder <= A[N-1:0];
                  end else if (a_mag[2*N-1:N] >= b_mag) begin
                     state     <= DONE;
                     ready     <= 1'b1;
                     overflow  <= 1'b1;
                     Quotient  <= '1;
                     Remainder <= A[N-1:0];
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               prem <= prem_nx;
               alo  <= {alo[N-2:0], 1'b0};
               qacc <= q_fin[N-2:0];
               cnt  <= cnt + 1'b1;
               if (cnt == CW'(N - 1)) begin
                  state     <= DONE;
                  ready     <= 1'b1;
                  overflow  <= q_ovf;
                  Quotient  <= q_res;
                  Remainder <= r_res;
               end
            end
            DONE: begin
               if (!en) begin
                  state <= IDLE;
                  ready <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: directed vectors with a scoreboard queue
// and an independent monitor on the rising edge of ready.
module tb_restoring_divider;
   localparam int N = 8;

   typedef struct {
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic         dz;
      logic         ov;
      int           start;
      int           lat;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           en = 1'b0;
   logic [2*N-1:0] A = '0;
   logic [N-1:0]   B = '0;
   logic [N-1:0]   Quotient;
   logic [N-1:0]   Remainder;
   logic           ready;
   logic           div_zero;
   logic           overflow;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   logic rdy_q = 1'b0;
   exp_t sb[$];

   restoring_divider #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .A         (A),
      .B         (B),
      .Quotient  (Quotient),
      .Remainder (Remainder),
      .ready     (ready),
      .div_zero  (div_zero),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (ready && !rdy_q) begin
         if (sb.size() == 0) begin
            chk("unexpected_ready", 32'(ready), 32'(0));
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("quotient", 32'(Quotient), 32'(e.q));
            chk("remainder", 32'(Remainder), 32'(e.r));
            chk("div_zero", 32'(div_zero), 32'(e.dz));
            chk("overflow", 32'(overflow), 32'(e.ov));
            chk("latency", 32'(cyc - e.start), 32'(e.lat));
         end
      end
      rdy_q = ready;
   end

   task automatic start_op(input logic [2*N-1:0] a, input logic [N-1:0] b,
                           input logic [N-1:0] q, input logic [N-1:0] r,
                           input logic dz, input logic ov, input int lat);
      exp_t e;
      @(negedge clk);
      A = a;
      B = b;
      en = 1'b1;
      e.q = q;
      e.r = r;
      e.dz = dz;
      e.ov = ov;
      e.start = cyc + 1;
      e.lat = lat;
      sb.push_back(e);
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      @(negedge clk);
      while (!ready && n < 40) begin
         A = A ^ 16'h5a3c;
         B = B + 8'd3;
         @(negedge clk);
         n++;
      end
      if (!ready) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: ready=%0b required 1", tag, ready);
      end
   endtask

   task automatic release_op();
      en = 1'b0;
      @(negedge clk);
      chk("ready_drop", 32'(ready), 32'(0));
   endtask

   task automatic run_op(input logic [2*N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] q, input logic [N-1:0] r,
                         input logic dz, input logic ov, input int lat);
      start_op(a, b, q, r, dz, ov, lat);
      wait_ready("op");
      release_op();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_quotient", 32'(Quotient), 32'(0));
      chk("rst_remainder", 32'(Remainder), 32'(0));
      chk("rst_ready", 32'(ready), 32'(0));
      chk("rst_div_zero", 32'(div_zero), 32'(0));
      chk("rst_overflow", 32'(overflow), 32'(0));
      rst_n = 1'b1;

`ifdef DIVIDER_SIGNED_EN
      run_op(16'hFC18, 8'd7, 8'hFF, 8'h18, 1'b0, 1'b1, 8);
      run_op(16'hFC7C, 8'd7, 8'h80, 8'hFC, 1'b0, 1'b0, 8);
      run_op(16'd129, 8'd1, 8'hFF, 8'h81, 1'b0, 1'b1, 8);
      run_op(16'd100, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0, 8);
      run_op(16'hFF9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0, 8);
      run_op(16'd895, 8'd7, 8'd127, 8'd6, 1'b0, 1'b0, 8);
`else
      run_op(16'd129, 8'd1, 8'd129, 8'd0, 1'b0, 1'b0, 8);
      run_op(16'd1000, 8'd7, 8'd142, 8'd6, 1'b0, 1'b0, 8);
      run_op(16'd65279, 8'd255, 8'd255, 8'd254, 1'b0, 1'b0, 8);
      run_op(16'd65535, 8'd255, 8'hFF, 8'hFF, 1'b0, 1'b1, 0);
      run_op(16'h0500, 8'd5, 8'hFF, 8'h00, 1'b0, 1'b1, 0);
      run_op(16'h04FF, 8'd5, 8'd255, 8'd4, 1'b0, 1'b0, 8);
`endif
      run_op(16'h1234, 8'd0, 8'hFF, 8'h34, 1'b1, 1'b0, 0);
      run_op(16'd0, 8'd5, 8'd0, 8'd0, 1'b0, 1'b0, 8);
      run_op(16'd12345, 8'd100, 8'd123, 8'd45, 1'b0, 1'b0, 8);

      // en dropped mid-calculation: ready must pulse for one cycle
      start_op(16'd12345, 8'd100, 8'd123, 8'd45, 1'b0, 1'b0, 8);
      repeat (3) @(negedge clk);
      en = 1'b0;
      wait_ready("drop");
      @(negedge clk);
      chk("pulse_ready", 32'(ready), 32'(0));

      // en held high: DONE persists, no restart on new operands
      start_op(16'd200, 8'd3, 8'd66, 8'd2, 1'b0, 1'b0, 8);
      wait_ready("hold");
      for (int i = 0; i < 4; i++) begin
         A = 16'd7;
         B = 8'd2;
         @(negedge clk);
         chk("hold_ready", 32'(ready), 32'(1));
         chk("hold_quotient", 32'(Quotient), 32'(66));
      end
      release_op();

      // reset at edge k+4 aborts the operation
      @(negedge clk);
      A = 16'd1000;
      B = 8'd9;
      en = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_quotient", 32'(Quotient), 32'(0));
      chk("abort_remainder", 32'(Remainder), 32'(0));
      chk("abort_ready", 32'(ready), 32'(0));
      chk("abort_div_zero", 32'(div_zero), 32'(0));
      chk("abort_overflow", 32'(overflow), 32'(0));
      rst_n = 1'b1;
      en = 1'b0;
      repeat (2) @(negedge clk);
      chk("abort_idle_ready", 32'(ready), 32'(0));
      run_op(16'd1000, 8'd9, 8'd111, 8'd1, 1'b0, 1'b0, 8);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 32'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
